// File: rtl/complex_pkg.sv
// Shared complex-sample helpers.
// Purpose : packing helpers and the round/saturate arithmetic used by the complex datapath
//           blocks and their benches. All arithmetic is carried at MaxW bits so any
//           component width up to MaxW-2 rounds without intermediate overflow.
// Contents: re()/im() component extraction, round_he() convergent right shift,
//           saturate() clamp with overflow flag, round_sat() = both.
package complex_pkg;

   localparam int unsigned MaxW = 64;

   typedef logic signed [MaxW-1:0] wide_t;

   typedef struct packed {
      logic  ovf;
      wide_t y;
   } sat_t;

   // Sign-extend the low w bits of v to MaxW bits.
   function automatic wide_t sext(input logic [MaxW-1:0] v, input int unsigned w);
      logic [MaxW-1:0] t;
      t = v << (MaxW - w);
      return $signed(t) >>> (MaxW - w);
   endfunction

   // Real part: low w bits of a packed {imag, real} word.
   function automatic wide_t re(input logic [2*MaxW-1:0] c, input int unsigned w);
      return sext(c[MaxW-1:0], w);
   endfunction

   // Imaginary part: bits [2w-1:w] of a packed {imag, real} word.
   function automatic wide_t im(input logic [2*MaxW-1:0] c, input int unsigned w);
      logic [2*MaxW-1:0] t;
      t = c >> w;
      return sext(t[MaxW-1:0], w);
   endfunction

   // Arithmetic right shift with round-half-to-even.
   function automatic wide_t round_he(input wide_t x, input int unsigned shift);
      wide_t bias;
      wide_t lsb;
      if (shift == 0) begin
         return x;
      end
      bias = (wide_t'(1) <<< (shift - 1)) - wide_t'(1);
      lsb  = x >>> shift;
      // Bumping the bias by the kept LSB turns exact halves toward the even neighbour.
      if (lsb[0]) begin
         bias = bias + wide_t'(1);
      end
      return (x + bias) >>> shift;
   endfunction

   // Clamp y to a signed w-bit range; ovf flags a clamp.
   function automatic sat_t saturate(input wide_t y, input int unsigned w);
      wide_t hi;
      wide_t lo;
      sat_t  r;
      hi    = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
      lo    = -hi - wide_t'(1);
      r.ovf = 1'b0;
      r.y   = y;
      if (y > hi) begin
         r.ovf = 1'b1;
         r.y   = hi;
      end else if (y < lo) begin
         r.ovf = 1'b1;
         r.y   = lo;
      end
      return r;
   endfunction

   function automatic sat_t round_sat(input wide_t x, input int unsigned shift,
                                      input int unsigned w);
      return saturate(round_he(x, shift), w);
   endfunction

endpackage

// File: rtl/skid_buffer.sv
// Two-entry skid buffer with a registered ready.
// Purpose : breaks the ready path between the downstream pipeline and the upstream
//           producer; the second entry catches the sample launched while ready falls.
// Ports   : clk, reset (async active-low), in_valid/in_ready/in_data (upstream),
//           out_valid/out_ready/out_data (downstream).
module skid_buffer #(
   parameter int unsigned WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   logic [WIDTH-1:0] mem_q [2];
   logic             wr_ptr_q;
   logic             rd_ptr_q;
   logic [1:0]       count_q;
   logic [1:0]       count_d;
   logic             ready_q;
   logic             push;
   logic             pop;

   assign push      = in_valid & ready_q;
   assign pop       = (count_q != 2'd0) & out_ready;
   assign count_d   = count_q + {1'b0, push} - {1'b0, pop};
   assign in_ready  = ready_q;
   assign out_valid = (count_q != 2'd0);
   assign out_data  = mem_q[rd_ptr_q];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 2; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
         ready_q  <= 1'b0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= in_data;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q <= count_d;
         // Ready is taken from the next occupancy, so a full buffer never sees a push.
         ready_q <= (count_d != 2'd2);
      end
   end

endmodule

// File: rtl/complex_narrow.sv
// Complex sample narrower.
// Purpose : takes signed IN_WIDTH-bit {imag, real} products and emits OUT_WIDTH-bit
//           samples: convergent-rounding right shift by SHIFT, then saturation.
//           Skid buffer -> stage 1 (round) -> stage 2 (saturate, output register).
// Ports   : clk, reset (async active-low), s_valid/s_ready/s_data (input stream),
//           m_valid/m_ready/m_data/m_overflow (output stream), count_clear,
//           sat_count (saturating count of overflowed output transfers).
module complex_narrow
   import complex_pkg::*;
#(
   parameter int unsigned IN_WIDTH    = 32,
   parameter int unsigned OUT_WIDTH   = 16,
   parameter int unsigned SHIFT       = 15,
   parameter int unsigned COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic [2*IN_WIDTH-1:0]  s_data,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [2*OUT_WIDTH-1:0] m_data,
   output logic                   m_overflow,
   input  logic                   count_clear,
   output logic [COUNT_WIDTH-1:0] sat_count
);

   // Rounded values still need one bit beyond IN_WIDTH before saturation.
   localparam int unsigned RW = IN_WIDTH + 1;

   logic                   sk_valid;
   logic                   sk_ready;
   logic [2*IN_WIDTH-1:0]  sk_data;
   logic [2*MaxW-1:0]      sk_wide;

   logic                   s1_valid_q;
   logic signed [RW-1:0]   s1_re_q;
   logic signed [RW-1:0]   s1_im_q;
   logic signed [RW-1:0]   s1_re_d;
   logic signed [RW-1:0]   s1_im_d;

   logic                   m_valid_q;
   logic [2*OUT_WIDTH-1:0] m_data_q;
   logic [2*OUT_WIDTH-1:0] m_data_d;
   logic                   m_overflow_q;
   logic [COUNT_WIDTH-1:0] count_q;
   logic [COUNT_WIDTH-1:0] count_d;

   logic                   out_adv;
   logic                   s1_adv;
   sat_t                   re_sat;
   sat_t                   im_sat;
   logic                   unused_sat;

   skid_buffer #(
      .WIDTH (2*IN_WIDTH)
   ) u_skid (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (s_valid),
      .in_ready  (s_ready),
      .in_data   (s_data),
      .out_valid (sk_valid),
      .out_ready (sk_ready),
      .out_data  (sk_data)
   );

   // Each stage moves when the slot ahead of it is empty or being drained this edge.
   assign out_adv  = ~m_valid_q | m_ready;
   assign s1_adv   = ~s1_valid_q | out_adv;
   assign sk_ready = s1_adv;

   always_comb begin
      sk_wide                 = '0;
      sk_wide[2*IN_WIDTH-1:0] = sk_data;
      s1_re_d = RW'(round_he(re(sk_wide, IN_WIDTH), SHIFT));
      s1_im_d = RW'(round_he(im(sk_wide, IN_WIDTH), SHIFT));
   end

   always_comb begin
      re_sat   = saturate(wide_t'(s1_re_q), OUT_WIDTH);
      im_sat   = saturate(wide_t'(s1_im_q), OUT_WIDTH);
      m_data_d = {im_sat.y[OUT_WIDTH-1:0], re_sat.y[OUT_WIDTH-1:0]};
   end

   // Clamped results are in range, so the discarded upper bits are only sign copies.
   assign unused_sat = ^{re_sat.y[MaxW-1:OUT_WIDTH], im_sat.y[MaxW-1:OUT_WIDTH]};

   always_comb begin
      count_d = count_q;
      if (count_clear) begin
         count_d = '0;
      end else if (m_valid_q && m_ready && m_overflow_q && (count_q != '1)) begin
         count_d = count_q + COUNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_valid_q   <= 1'b0;
         s1_re_q      <= '0;
         s1_im_q      <= '0;
         m_valid_q    <= 1'b0;
         m_data_q     <= '0;
         m_overflow_q <= 1'b0;
         count_q      <= '0;
      end else begin
         if (s1_adv) begin
            s1_valid_q <= sk_valid;
         end
         if (s1_adv && sk_valid) begin
            s1_re_q <= s1_re_d;
            s1_im_q <= s1_im_d;
         end
         if (out_adv) begin
            m_valid_q <= s1_valid_q;
         end
         if (out_adv && s1_valid_q) begin
            m_data_q     <= m_data_d;
            m_overflow_q <= re_sat.ovf | im_sat.ovf;
         end
         count_q <= count_d;
      end
   end

   assign m_valid    = m_valid_q;
   assign m_data     = m_data_q;
   assign m_overflow = m_overflow_q;
   assign sat_count  = count_q;

endmodule

// File: tb/tb_complex_narrow.sv
// Bench for complex_narrow (default parameters: 32-bit in, 16-bit out, SHIFT 15).
module tb_complex_narrow;

   localparam int     Shift  = 15;
   localparam int     OutW   = 16;
   localparam longint MaxIn  = (64'sd1 <<< 31) - 64'sd1;
   localparam longint MinIn  = -(64'sd1 <<< 31);

   logic        clk = 1'b0;
   logic        reset;
   logic        s_valid;
   logic        s_ready;
   logic [63:0] s_data;
   logic        m_valid;
   logic        m_ready;
   logic [31:0] m_data;
   logic        m_overflow;
   logic        count_clear;
   logic [15:0] sat_count;

   always #5 clk = ~clk;

   complex_narrow dut (
      .clk         (clk),
      .reset       (reset),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_data      (s_data),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_data      (m_data),
      .m_overflow  (m_overflow),
      .count_clear (count_clear),
      .sat_count   (sat_count)
   );

   int          n_vec;
   int          n_err;
   int          n_out;
   int          cyc;
   int          first_acc;
   int          first_valid;
   bit          acc;
   bit          stall_hold;
   logic [31:0] held_data;
   logic        held_ovf;
   logic [31:0] last_data;
   logic        last_ovf;
   int          exp_count;
   logic [31:0] q_data[$];
   bit          q_ovf[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: floor division, remainder compare for ties-to-even, then clamp.
   function automatic longint model_rs(input longint x, output bit ov);
      longint q, r, half, hi, lo;
      q    = x >>> Shift;
      r    = x - (q <<< Shift);
      half = longint'(1) <<< (Shift - 1);
      if (r > half || (r == half && q[0])) q = q + 1;
      hi = (longint'(1) <<< (OutW - 1)) - 1;
      lo = -hi - 1;
      ov = 1'b0;
      if (q > hi) begin
         q  = hi;
         ov = 1'b1;
      end else if (q < lo) begin
         q  = lo;
         ov = 1'b1;
      end
      return q;
   endfunction

   function automatic logic [63:0] mk(input longint r, input longint i);
      logic [63:0] a, b;
      a = r;
      b = i;
      return {b[31:0], a[31:0]};
   endfunction

   function automatic longint rnd_comp();
      int v;
      v = $urandom;
      return longint'(v) >>> $urandom_range(0, 20);
   endfunction

   task automatic push_model(input logic [63:0] d);
      longint yr, yi;
      bit     ovr, ovi;
      yr = model_rs(longint'($signed(d[31:0])), ovr);
      yi = model_rs(longint'($signed(d[63:32])), ovi);
      q_data.push_back({yi[15:0], yr[15:0]});
      q_ovf.push_back(ovr | ovi);
   endtask

   // One clock: inputs already driven; sample at negedge, then advance past posedge.
   task automatic step();
      logic [31:0] ed;
      bit          eo;
      @(negedge clk);
      chk("sat_count", sat_count, exp_count);
      if (stall_hold) begin
         chk("hold_valid", m_valid, 1);
         chk("hold_data", m_data, held_data);
         chk("hold_ovf", m_overflow, held_ovf);
      end
      if (m_valid && first_valid < 0) first_valid = cyc;
      acc = s_valid && s_ready;
      if (m_valid && m_ready) begin
         n_out++;
         last_data = m_data;
         last_ovf  = m_overflow;
         if (q_data.size() == 0) begin
            chk("spurious_out", m_valid, 0);
         end else begin
            ed = q_data.pop_front();
            eo = q_ovf.pop_front();
            chk("out_data", m_data, ed);
            chk("out_ovf", m_overflow, eo);
            if (!count_clear && eo && exp_count < 65535) exp_count++;
         end
      end
      if (count_clear) exp_count = 0;
      stall_hold = m_valid && !m_ready;
      held_data  = m_data;
      held_ovf   = m_overflow;
      if (acc) begin
         push_model(s_data);
         if (first_acc < 0) first_acc = cyc + 1;
      end
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic send(input logic [63:0] d);
      bit ok;
      ok      = 1'b0;
      s_valid = 1'b1;
      s_data  = d;
      for (int k = 0; k < 64; k++) begin
         step();
         if (acc) begin
            ok = 1'b1;
            break;
         end
      end
      s_valid = 1'b0;
      if (!ok) chk("send_timeout", acc, 1);
   endtask

   task automatic drain();
      m_ready = 1'b1;
      s_valid = 1'b0;
      for (int k = 0; k < 32 && q_data.size() != 0; k++) step();
      step();
      step();
      chk("drain_left", q_data.size(), 0);
   endtask

   initial begin
      int          sent;
      int          guard;
      int          outs_before;
      logic [63:0] cur;

      reset       = 1'b0;
      s_valid     = 1'b0;
      s_data      = '0;
      m_ready     = 1'b0;
      count_clear = 1'b0;
      n_vec       = 0;
      n_err       = 0;
      n_out       = 0;
      cyc         = 0;
      first_acc   = -1;
      first_valid = -1;
      stall_hold  = 1'b0;
      exp_count   = 0;

      // Reset values.
      #12;
      chk("rst_s_ready", s_ready, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_m_overflow", m_overflow, 0);
      chk("rst_sat_count", sat_count, 0);
      reset = 1'b1;
      #1;
      chk("rel_s_ready", s_ready, 0);
      @(posedge clk);
      cyc++;
      #1;
      chk("first_s_ready", s_ready, 1);

      // Rounding ties: 0.5, 1.5, 2.5, -0.5, -1.5.
      m_ready = 1'b1;
      send(mk(16384, 0));
      send(mk(49152, 0));
      send(mk(81920, 0));
      send(mk(-16384, 0));
      send(mk(-49152, 0));
      drain();
      chk("latency", first_valid - first_acc, 2);

      // Saturation of both components.
      send(mk(MaxIn, MinIn));
      drain();
      chk("sat_data", last_data, 32'h8000_7fff);
      chk("sat_ovf", last_ovf, 1);
      chk("sat_count_1", sat_count, 1);

      // Square sweep: i*i scaled by 2^15 in imag.
      count_clear = 1'b1;
      step();
      count_clear = 1'b0;
      for (int i = 0; i < 256; i++) send(mk(0, longint'(i * i) <<< 15));
      drain();
      chk("sweep_count", sat_count, 74);

      // Random data with random downstream stalls.
      sent  = 0;
      guard = 0;
      cur   = mk(rnd_comp(), rnd_comp());
      while (sent < 256 && guard < 4000) begin
         s_valid = 1'b1;
         s_data  = cur;
         m_ready = 1'($urandom_range(0, 1));
         step();
         if (acc) begin
            sent++;
            cur = mk(rnd_comp(), rnd_comp());
         end
         guard++;
      end
      s_valid = 1'b0;
      chk("bp_sent", sent, 256);
      drain();

      // Clear coinciding with an overflow transfer.
      m_ready = 1'b0;
      send(mk(MaxIn, 0));
      for (int k = 0; k < 10 && !m_valid; k++) step();
      chk("clr_wait_valid", m_valid, 1);
      count_clear = 1'b1;
      m_ready     = 1'b1;
      step();
      count_clear = 1'b0;
      chk("clear_prio", sat_count, 0);
      drain();

      // Counter sticks at all-ones.
      m_ready = 1'b1;
      s_valid = 1'b1;
      s_data  = mk(MaxIn, MaxIn);
      sent    = 0;
      guard   = 0;
      while (sent < 65536 + 3 && guard < 70000) begin
         step();
         if (acc) sent++;
         guard++;
      end
      s_valid = 1'b0;
      drain();
      chk("count_stick", sat_count, 16'hffff);

      // Reset with three samples in flight.
      m_ready = 1'b0;
      send(mk(16384, 16384));
      send(mk(49152, -49152));
      send(mk(MaxIn, MinIn));
      #2;
      reset = 1'b0;
      #1;
      chk("mid_rst_m_valid", m_valid, 0);
      chk("mid_rst_s_ready", s_ready, 0);
      chk("mid_rst_m_data", m_data, 0);
      chk("mid_rst_count", sat_count, 0);
      q_data.delete();
      q_ovf.delete();
      stall_hold = 1'b0;
      exp_count  = 0;
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("post_rel_s_ready", s_ready, 0);
      @(posedge clk);
      cyc++;
      #1;
      chk("post_rel_ready1", s_ready, 1);
      chk("post_rel_m_valid", m_valid, 0);
      outs_before = n_out;
      m_ready     = 1'b1;
      send(mk(81920, -49152));
      drain();
      chk("post_rst_outs", n_out - outs_before, 1);
      chk("post_rst_data", last_data, 32'hfffe_0002);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
